// File: rtl/bcd_to_fnd_decoder.sv
// ---------------------------------------------------------------------------
// bcd_to_fnd_decoder
//
// Drives one 4-digit common-anode 7-segment (FND) display. A 4-bit value is
// turned into an active-low segment font, and a 2-bit digit index is turned
// into an active-low one-hot anode enable. Both outputs are registered, which
// gives one cycle of latency and no combinational path from inputs to pins.
// A shared enable blanks both paths together.
//
// Ports:
//   i_clk          system clock, rising-edge active
//   i_reset        synchronous reset, active-high; blanks the display
//   i_value        value for the selected digit, 0x0..0xF (hex glyphs A..F)
//   i_DigitSelect  digit index, 0 = rightmost, 3 = leftmost
//   i_En           display enable, active-high; 0 blanks the display
//   o_digit        anode enables, active-low, bit n low lights digit n
//   o_font         segment drives, active-low, order {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_to_fnd_decoder (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_value,
    input  logic [1:0] i_DigitSelect,
    input  logic       i_En,
    output logic [3:0] o_digit,
    output logic [7:0] o_font
);

    localparam logic [3:0] DIGIT_BLANK = 4'b1111;
    localparam logic [7:0] FONT_BLANK  = 8'hFF;

    // Segment pattern for one hex value. Bit 7 (decimal point) stays high,
    // i.e. off, in every glyph.
    function automatic logic [7:0] font_of(input logic [3:0] value);
        logic [7:0] font;
        case (value)
            4'h0:    font = 8'hC0;
            4'h1:    font = 8'hF9;
            4'h2:    font = 8'hA4;
            4'h3:    font = 8'hB0;
            4'h4:    font = 8'h99;
            4'h5:    font = 8'h92;
            4'h6:    font = 8'h82;
            4'h7:    font = 8'hF8;
            4'h8:    font = 8'h80;
            4'h9:    font = 8'h90;
            4'hA:    font = 8'h88;
            4'hB:    font = 8'h83;
            4'hC:    font = 8'hC6;
            4'hD:    font = 8'hA1;
            4'hE:    font = 8'h86;
            4'hF:    font = 8'h8E;
            default: font = FONT_BLANK;
        endcase
        return font;
    endfunction

    // Active-low one-hot anode enable for one digit index.
    function automatic logic [3:0] digit_of(input logic [1:0] sel);
        logic [3:0] digit;
        case (sel)
            2'b00:   digit = 4'b1110;
            2'b01:   digit = 4'b1101;
            2'b10:   digit = 4'b1011;
            2'b11:   digit = 4'b0111;
            default: digit = DIGIT_BLANK;
        endcase
        return digit;
    endfunction

    logic [7:0] font_s;
    logic [3:0] digit_s;
    logic [7:0] font_r;
    logic [3:0] digit_r;

    // Next output values: decoded glyph/anode when enabled, blank otherwise.
    always_comb begin
        font_s  = FONT_BLANK;
        digit_s = DIGIT_BLANK;
        if (i_En) begin
            font_s  = font_of(i_value);
            digit_s = digit_of(i_DigitSelect);
        end else begin
            font_s  = FONT_BLANK;
            digit_s = DIGIT_BLANK;
        end
    end

    // Output registers; reset takes priority over enable and data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            font_r  <= FONT_BLANK;
            digit_r <= DIGIT_BLANK;
        end else begin
            font_r  <= font_s;
            digit_r <= digit_s;
        end
    end

    assign o_font  = font_r;
    assign o_digit = digit_r;

endmodule

// File: tb/tb_bcd_to_fnd_decoder.sv
module tb_bcd_to_fnd_decoder;

    logic       i_clk;
    logic       i_reset;
    logic [3:0] i_value;
    logic [1:0] i_DigitSelect;
    logic       i_En;
    logic [3:0] o_digit;
    logic [7:0] o_font;

    int total_cnt;
    int pass_cnt;

    // Reference glyph table straight from the display font list.
    logic [7:0] font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                                  8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83,
                                  8'hC6, 8'hA1, 8'h86, 8'h8E};

    bcd_to_fnd_decoder dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_value       (i_value),
        .i_DigitSelect (i_DigitSelect),
        .i_En          (i_En),
        .o_digit       (o_digit),
        .o_font        (o_font)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_font(input logic rst, input logic en, input logic [3:0] v);
        if (rst || !en) return 8'hFF;
        return font_tab[v];
    endfunction

    function automatic logic [3:0] model_digit(input logic rst, input logic en, input logic [1:0] s);
        logic [3:0] one;
        if (rst || !en) return 4'b1111;
        one = 4'b0001 << s;
        return ~one;
    endfunction

    // Apply one set of inputs, clock once, and compare both outputs.
    task automatic step(input logic rst, input logic en, input logic [3:0] v,
                        input logic [1:0] s, input string tag);
        logic [7:0] exp_font;
        logic [3:0] exp_digit;
        i_reset       = rst;
        i_En          = en;
        i_value       = v;
        i_DigitSelect = s;
        exp_font  = model_font(rst, en, v);
        exp_digit = model_digit(rst, en, s);
        @(posedge i_clk);
        #1;
        total_cnt++;
        assert (o_font === exp_font) pass_cnt++;
        else $error("FAIL %s font: observed %h expected %h (rst=%0d en=%0d v=%h)",
                    tag, o_font, exp_font, rst, en, v);
        total_cnt++;
        assert (o_digit === exp_digit) pass_cnt++;
        else $error("FAIL %s digit: observed %b expected %b (rst=%0d en=%0d sel=%0d)",
                    tag, o_digit, exp_digit, rst, en, s);
    endtask

    initial begin
        logic [3:0] blank_vals [6];
        logic       r_rst;
        logic       r_en;
        total_cnt = 0;
        pass_cnt  = 0;
        i_reset = 1'b1;
        i_En = 1'b1;
        i_value = 4'h8;
        i_DigitSelect = 2'b00;
        blank_vals = '{4'h0, 4'h6, 4'h7, 4'h9, 4'h8, 4'h4};

        // Reset held for two cycles, then first decode one edge later.
        step(1'b1, 1'b1, 4'h8, 2'b00, "reset0");
        step(1'b1, 1'b1, 4'h8, 2'b00, "reset1");
        step(1'b0, 1'b1, 4'h8, 2'b00, "post_reset");

        // Digit sweep.
        for (int d = 0; d < 4; d++)
            step(1'b0, 1'b1, 4'h3, 2'(d), "digit_sweep");

        // Font sweep with a one-cycle reset in the middle.
        for (int v = 0; v < 16; v++) begin
            if (v == 7)
                step(1'b1, 1'b1, 4'(v), 2'(v), "mid_reset");
            step(1'b0, 1'b1, 4'(v), 2'(v), "font_sweep");
        end

        // Blanking while data moves.
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b0, blank_vals[k], 2'b01, "blanking");

        // Enable rises together with data change.
        step(1'b0, 1'b0, 4'h4, 2'b01, "en_toggle_pre");
        step(1'b0, 1'b1, 4'h2, 2'b11, "en_toggle");
        // Enable falls together with data change.
        step(1'b0, 1'b0, 4'hA, 2'b10, "en_fall");

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            r_rst = ($urandom_range(0, 19) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            step(r_rst, r_en, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), "random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
